// File: rtl/matrix_out_streamer.sv
// Streams a captured systolic-array result matrix out one row per handshake.
// A rising edge of matrix_rdy snapshots the whole matrix; rows drain under valid/ready flow control.
module matrix_out_streamer #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16,
  localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            matrix_rdy,
  input  logic [ROWS*COLS*WORD_SIZE-1:0]  output_matrix,
  input  logic                            out_ready,
  input  logic                            clr_overrun,
  output logic                            out_valid,
  output logic [COLS*WORD_SIZE-1:0]       out_data,
  output logic [RW-1:0]                   out_row_idx,
  output logic                            out_last,
  output logic                            busy,
  output logic                            overrun,
  output logic [7:0]                      frame_count
);

  localparam int ROW_W = COLS * WORD_SIZE;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state_q;
  logic              rdy_q;
  logic [RW-1:0]     row_q;
  logic [ROW_W-1:0]  buf_q [ROWS];
  logic              out_valid_q;
  logic              out_last_q;
  logic [ROW_W-1:0]  out_data_q;
  logic [RW-1:0]     out_row_idx_q;
  logic              overrun_q;
  logic [7:0]        frame_count_q;

  logic              startEvent;
  logic              transfer;
  logic              onLastRow;
  logic              lastTransfer;
  logic              loadMatrix;
  logic [RW-1:0]     nextRow;

  assign startEvent   = matrix_rdy & ~rdy_q;
  assign transfer     = (state_q == STREAM) & out_ready;
  assign onLastRow    = (row_q == LAST_ROW);
  assign lastTransfer = transfer & onLastRow;
  // A new matrix is accepted when idle, or exactly as the last row leaves (no bubble).
  assign loadMatrix   = startEvent & ((state_q == IDLE) | lastTransfer);
  assign nextRow      = row_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      rdy_q         <= 1'b0;
      row_q         <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
      out_row_idx_q <= '0;
      overrun_q     <= 1'b0;
      frame_count_q <= 8'd0;
      for (int r = 0; r < ROWS; r++) begin
        buf_q[r] <= '0;
      end
    end else begin
      rdy_q <= matrix_rdy;

      if (clr_overrun) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
        STREAM: begin
          if (transfer && !onLastRow) begin
            row_q         <= nextRow;
            out_data_q    <= buf_q[nextRow];
            out_row_idx_q <= nextRow;
            out_last_q    <= (nextRow == LAST_ROW);
          end else if (lastTransfer) begin
            frame_count_q <= frame_count_q + 8'd1;
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
          end
          // Set placed after the clear so a simultaneous set wins.
          if (startEvent && !lastTransfer) begin
            overrun_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Later assignments override the drain/idle updates above.
      if (loadMatrix) begin
        state_q       <= STREAM;
        row_q         <= '0;
        out_valid_q   <= 1'b1;
        out_data_q    <= output_matrix[ROW_W-1:0];
        out_row_idx_q <= '0;
        out_last_q    <= (ROWS == 1);
        for (int r = 0; r < ROWS; r++) begin
          buf_q[r] <= output_matrix[r*ROW_W +: ROW_W];
        end
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_row_idx = out_row_idx_q;
  assign out_last    = out_last_q;
  assign busy        = (state_q == STREAM);
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_matrix_out_streamer.sv
// Randomized and directed bench for matrix_out_streamer, checked against a
// row-queue reference model of the drained matrix.
module tb_matrix_out_streamer;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int WS    = 16;
  localparam int RW    = 2;
  localparam int ROW_W = COLS * WS;
  localparam int MAT_W = ROWS * ROW_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              matrix_rdy;
  logic [MAT_W-1:0]  output_matrix;
  logic              out_ready;
  logic              clr_overrun;
  logic              out_valid;
  logic [ROW_W-1:0]  out_data;
  logic [RW-1:0]     out_row_idx;
  logic              out_last;
  logic              busy;
  logic              overrun;
  logic [7:0]        frame_count;

  always #5 clk = ~clk;

  matrix_out_streamer #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS)) dut (
    .clk           (clk),
    .rst           (rst),
    .matrix_rdy    (matrix_rdy),
    .output_matrix (output_matrix),
    .out_ready     (out_ready),
    .clr_overrun   (clr_overrun),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_row_idx   (out_row_idx),
    .out_last      (out_last),
    .busy          (busy),
    .overrun       (overrun),
    .frame_count   (frame_count)
  );

  // Reference model: rows still owed to the consumer, front = row on the bus.
  typedef struct {
    logic [ROW_W-1:0] data;
    int               idx;
  } rowT;

  rowT              rowQueue[$];
  logic             rdyPrevM;
  logic             overrunM;
  logic [7:0]       framesM;
  logic [ROW_W-1:0] holdData;
  int               holdIdx;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep(input logic mr, input logic rdy, input logic clr, input logic rstn);
    logic start;
    logic wasBusy;
    logic drained;
    rowT  item;
    if (!rstn) begin
      rowQueue.delete();
      rdyPrevM = 1'b0;
      overrunM = 1'b0;
      framesM  = 8'd0;
      holdData = '0;
      holdIdx  = 0;
      return;
    end
    start    = mr && !rdyPrevM;
    rdyPrevM = mr;
    wasBusy  = (rowQueue.size() > 0);
    drained  = 1'b0;
    if (wasBusy && rdy) begin
      if (rowQueue[0].idx == ROWS - 1) begin
        framesM = framesM + 8'd1;
        drained = 1'b1;
      end
      void'(rowQueue.pop_front());
    end
    if (clr) overrunM = 1'b0;
    if (start) begin
      if (!wasBusy || drained) begin
        for (int r = 0; r < ROWS; r++) begin
          item.data = output_matrix[r*ROW_W +: ROW_W];
          item.idx  = r;
          rowQueue.push_back(item);
        end
      end else begin
        overrunM = 1'b1;
      end
    end
    if (rowQueue.size() > 0) begin
      holdData = rowQueue[0].data;
      holdIdx  = rowQueue[0].idx;
    end
  endtask

  task automatic checkAll();
    logic v;
    v = (rowQueue.size() > 0);
    checkOutput("out_valid",   64'(out_valid),   64'(v));
    checkOutput("out_data",    64'(out_data),    64'(holdData));
    checkOutput("out_row_idx", 64'(out_row_idx), 64'(holdIdx));
    checkOutput("out_last",    64'(out_last),    64'(v && (holdIdx == ROWS - 1)));
    checkOutput("busy",        64'(busy),        64'(v));
    checkOutput("overrun",     64'(overrun),     64'(overrunM));
    checkOutput("frame_count", 64'(frame_count), 64'(framesM));
  endtask

  // Called at a falling edge: drive, advance model, wait one cycle, then compare.
  task automatic applyStimulus(input logic mr, input logic rdy, input logic clr, input logic rstn);
    matrix_rdy  = mr;
    out_ready   = rdy;
    clr_overrun = clr;
    rst         = rstn;
    modelStep(mr, rdy, clr, rstn);
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  task automatic randomMatrix();
    for (int i = 0; i < MAT_W / 32; i++) begin
      output_matrix[i*32 +: 32] = $urandom();
    end
  endtask

  int         bpPattern[12] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 1};
  logic       mrR;

  initial begin
    rst           = 1'b0;
    matrix_rdy    = 1'b0;
    out_ready     = 1'b0;
    clr_overrun   = 1'b0;
    output_matrix = '0;
    modelStep(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Basic drain with element (r,c) = 0x0100*r + c.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        output_matrix[(r*COLS+c)*WS +: WS] = 16'(16'h0100 * r + c);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("basic_row0", 64'(out_data), 64'h0003_0002_0001_0000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("basic_frames", 64'(frame_count), 64'd1);

    // Backpressure.
    randomMatrix();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    foreach (bpPattern[i]) applyStimulus(1'b0, bpPattern[i] != 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);

    // Overrun while row 1 pending, then clear.
    randomMatrix();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    randomMatrix();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("overrun_set", 64'(overrun), 64'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("overrun_clr", 64'(overrun), 64'd0);

    // Back-to-back: new rising edge coincides with the row-3 transfer.
    randomMatrix();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    randomMatrix();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("b2b_valid", 64'(out_valid), 64'd1);
    checkOutput("b2b_idx",   64'(out_row_idx), 64'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);

    // Level hold: matrix_rdy high for 20 cycles.
    randomMatrix();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("level_overrun", 64'(overrun), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);

    // Reset while row 2 pending, then a fresh drain.
    randomMatrix();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_data", 64'(out_data), 64'd0);
    randomMatrix();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);

    // Randomized traffic.
    mrR = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      randomMatrix();
      if ($urandom_range(0, 5) == 0) mrR = ~mrR;
      applyStimulus(mrR, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 199) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
